// File: rtl/updown_counter_if.sv
// Counter bus: load/direction/data toward the counter, registered count back.
// Clock and reset stay outside the bundle as plain ports of the counter.
interface updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             updown;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_out;

  modport master (
    output load,
    output updown,
    output data,
    input  data_out
  );

  modport slave (
    input  load,
    input  updown,
    input  data,
    output data_out
  );
endinterface

// File: rtl/updown_counter.sv
// Loadable modulo-(MAX_COUNT+1) up/down counter with asynchronous active-low reset.
// There is no handshake: every rising edge either loads or steps the count.
module updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 11
) (
  input  logic              clk,
  input  logic              rst,
  updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  generate
    if (MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("updown_counter: MAX_COUNT does not fit in WIDTH bits");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_down;

  // Wrap is an explicit compare, so any MAX_COUNT below the binary limit works.
  always_comb begin
    w_load_val = (bus.data <= MAX_VAL) ? bus.data : '0;
    w_up       = (r_count == MAX_VAL) ? '0 : r_count + WIDTH'(1);
    w_down     = (r_count == '0) ? MAX_VAL : r_count - WIDTH'(1);
    w_next     = w_down;
    if (bus.load) begin
      w_next = w_load_val;
    end else if (bus.updown) begin
      w_next = w_up;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign bus.data_out = r_count;

  a_reset_zero : assert property (@(posedge clk)
    !rst |-> (r_count == '0));

  a_in_range : assert property (@(posedge clk)
    r_count <= MAX_VAL);

  a_load_in_range : assert property (@(posedge clk) disable iff (!rst)
    (bus.load && (bus.data <= MAX_VAL)) |=> (r_count == $past(bus.data)));

  a_load_coerce : assert property (@(posedge clk) disable iff (!rst)
    (bus.load && (bus.data > MAX_VAL)) |=> (r_count == '0));

  a_count_up : assert property (@(posedge clk) disable iff (!rst)
    (!bus.load && bus.updown) |=>
      (r_count == (($past(r_count) == MAX_VAL) ? '0 : $past(r_count) + WIDTH'(1))));

  a_count_down : assert property (@(posedge clk) disable iff (!rst)
    (!bus.load && !bus.updown) |=>
      (r_count == (($past(r_count) == '0) ? MAX_VAL : $past(r_count) - WIDTH'(1))));

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: directed vector table, async-reset sequences,
// and a random regression against a reference model through an expected queue.
module tb_updown_counter;

  localparam int WIDTH     = 4;
  localparam int MAX_COUNT = 11;

  logic clk;
  logic rst;

  updown_counter_if #(.WIDTH(WIDTH)) cif ();

  updown_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             ld;
    logic             ud;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp;
    string            name;
  } vec_t;

  logic [WIDTH-1:0] exp_q[$];
  string            name_q[$];
  int               checks;
  int               errors;
  logic [WIDTH-1:0] model_count;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: data_out=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check();
    logic [WIDTH-1:0] e;
    string            n;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL queue_empty: data_out=%0d with no expected value", cif.data_out);
      return;
    end
    e = exp_q.pop_front();
    n = name_q.pop_front();
    check(n, cif.data_out, e);
    checks++;
    if (cif.data_out > WIDTH'(MAX_COUNT)) begin
      errors++;
      $display("FAIL range_%s: data_out=%0d exceeds %0d", n, cif.data_out, MAX_COUNT);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic drive_cycle(input logic r, input logic ld, input logic ud,
                             input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp,
                             input string name);
    @(negedge clk);
    rst        = r;
    cif.load   = ld;
    cif.updown = ud;
    cif.data   = d;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  function automatic logic [WIDTH-1:0] ref_next(input logic [WIDTH-1:0] cur,
                                                input logic ld, input logic ud,
                                                input logic [WIDTH-1:0] d);
    int c;
    c = int'(cur);
    if (ld) return (int'(d) <= MAX_COUNT) ? d : '0;
    if (ud) return WIDTH'((c + 1) % (MAX_COUNT + 1));
    return WIDTH'((c + MAX_COUNT) % (MAX_COUNT + 1));
  endfunction

  vec_t tbl[$];

  initial begin
    logic             r_ld;
    logic             r_ud;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] e;

    checks = 0;
    errors = 0;

    tbl.push_back('{1'b1, 1'b0, 4'd5,  4'd5,  "load5"});
    tbl.push_back('{1'b1, 1'b1, 4'd14, 4'd0,  "load14_coerce"});
    tbl.push_back('{1'b1, 1'b0, 4'd9,  4'd9,  "load9"});
    tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd10, "up_10"});
    tbl.push_back('{1'b0, 1'b1, 4'd7,  4'd11, "up_11"});
    tbl.push_back('{1'b0, 1'b1, 4'd3,  4'd0,  "up_wrap0"});
    tbl.push_back('{1'b0, 1'b1, 4'd15, 4'd1,  "up_1"});
    tbl.push_back('{1'b1, 1'b1, 4'd2,  4'd2,  "load2"});
    tbl.push_back('{1'b0, 1'b0, 4'd0,  4'd1,  "down_1"});
    tbl.push_back('{1'b0, 1'b0, 4'd8,  4'd0,  "down_0"});
    tbl.push_back('{1'b0, 1'b0, 4'd0,  4'd11, "down_wrap11"});
    tbl.push_back('{1'b0, 1'b0, 4'd4,  4'd10, "down_10"});
    tbl.push_back('{1'b1, 1'b0, 4'd6,  4'd6,  "load6"});
    tbl.push_back('{1'b1, 1'b1, 4'd3,  4'd3,  "load_prio3"});
    tbl.push_back('{1'b0, 1'b0, 4'd9,  4'd2,  "dir_switch_down"});
    tbl.push_back('{1'b0, 1'b1, 4'd9,  4'd3,  "dir_switch_up"});
    tbl.push_back('{1'b1, 1'b0, 4'd11, 4'd11, "load_max"});
    tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd0,  "up_from_max"});
    tbl.push_back('{1'b1, 1'b1, 4'd12, 4'd0,  "load12_coerce"});
    tbl.push_back('{1'b0, 1'b0, 4'd1,  4'd11, "down_from_0"});
    tbl.push_back('{1'b1, 1'b0, 4'd15, 4'd0,  "load15_coerce"});

    cif.load   = 1'b0;
    cif.updown = 1'b0;
    cif.data   = '0;
    rst        = 1'b1;
    #1 rst = 1'b0;
    #2 check("reset_async", cif.data_out, '0);

    // Hold reset across edges while load is requested.
    @(negedge clk);
    cif.load = 1'b1;
    cif.data = 4'd7;
    @(posedge clk);
    #1 check("reset_hold_load", cif.data_out, '0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_cycle(1'b1, tbl[i].ld, tbl[i].ud, tbl[i].d, tbl[i].exp, tbl[i].name);
    end

    // Mid-cycle reset with count at 7, then release and count up.
    drive_cycle(1'b1, 1'b1, 1'b0, 4'd7, 4'd7, "load7");
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("mid_reset_immediate", cif.data_out, '0);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd5, 4'd0, "reset_over_load");
    drive_cycle(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, "post_reset_up");
    model_count = 4'd1;

    for (int i = 0; i < 1200; i++) begin
      r_ld = ($urandom_range(0, 5) == 0);
      r_ud = 1'($urandom_range(0, 1));
      r_d  = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        model_count = '0;
        drive_cycle(1'b0, r_ld, r_ud, r_d, '0, "rand_reset");
      end else begin
        e = ref_next(model_count, r_ld, r_ud, r_d);
        model_count = e;
        drive_cycle(1'b1, r_ld, r_ud, r_d, e, "rand");
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
